// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU control unit / host loader and mem_responder.
// master: CPU strobes, address/data buses and host loader inputs (driven toward memory).
// slave:  mem_responder side; returns read data, AR, loader handshake, readback and errors.
interface mem_responder_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) ();
  logic [1:0]    cpustate;   // 00 idle, 01 IN, 10 CHECK, 11 RUN
  logic [AW-1:0] abus;
  logic [DW-1:0] dbus;
  logic          arload;
  logic          arinc;
  logic          read;
  logic          membus;
  logic          write;
  logic          busmem;
  logic [DW-1:0] mem_dout;
  logic [AW-1:0] ar;
  logic          host_valid;
  logic [DW-1:0] host_data;
  logic          host_ready;
  logic          chk_valid;
  logic [DW-1:0] chk_data;
  logic          load_done;
  logic          range_err;
  logic          par_err;

  modport master (
    output cpustate, abus, dbus, arload, arinc, read, membus, write, busmem,
    output host_valid, host_data,
    input  mem_dout, ar, host_ready, chk_valid, chk_data, load_done, range_err, par_err
  );

  modport slave (
    input  cpustate, abus, dbus, arload, arinc, read, membus, write, busmem,
    input  host_valid, host_data,
    output mem_dout, ar, host_ready, chk_valid, chk_data, load_done, range_err, par_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory side of the CPU bus: holds AR, serves CPU read/write strobes (RUN) and the host
// program loader (IN) / readback (CHECK) into a single byte RAM.
// Ports: clk, rst (async, active-high), bus (mem_responder_if.slave: cpustate, abus, dbus,
//   CPU strobes, mem_dout, ar, host_valid/host_data/host_ready, chk_valid/chk_data,
//   load_done, range_err, par_err).
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per byte and flag
//   mismatches on CPU reads and readback responses (sticky par_err). Otherwise par_err = 0.
module mem_responder #(
  parameter int unsigned AW     = 16,
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned DW     = 8
) (
  input logic             clk,
  input logic             rst,
  mem_responder_if.slave  bus
);

  localparam int unsigned Depth = 2 ** MEM_AW;

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StChkRsp, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cpustate_q;
  logic [MEM_AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]       ar_q, ar_d;
  logic [DW-1:0]       chk_q, chk_d;
  logic                range_err_q, range_err_d;
  logic [DW-1:0]       mem_q [Depth];

  logic                run, in_range, cpu_rd, cpu_wr, cs_stable, ptr_last;
  logic                host_rdy, chk_vld, load_wr, done;
  logic [MEM_AW-1:0]   mem_idx;

  assign run       = (bus.cpustate == 2'b11);
  assign mem_idx   = ar_q[MEM_AW-1:0];
  assign in_range  = (ar_q[AW-1:MEM_AW] == '0);
  assign cpu_rd    = run & bus.read & bus.membus;
  // Any asserted read suppresses a same-cycle write.
  assign cpu_wr    = run & bus.write & bus.busmem & ~bus.read & in_range;
  assign cs_stable = (bus.cpustate == cpustate_q);
  assign ptr_last  = &ptr_q;

  // Address register: arload has priority over arinc; increment wraps naturally.
  always_comb begin
    ar_d = ar_q;
    if (run) begin
      if (bus.arload)     ar_d = bus.abus;
      else if (bus.arinc) ar_d = ar_q + AW'(1);
    end
  end

  assign range_err_d = run & ((bus.read & bus.membus) | (bus.write & bus.busmem)) & ~in_range;

  // Loader / readback FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    chk_d    = chk_q;
    host_rdy = 1'b0;
    chk_vld  = 1'b0;
    load_wr  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cpustate == 2'b01) begin
          state_d = StLoad;
          ptr_d   = '0;
        end else if (bus.cpustate == 2'b10) begin
          state_d = StCheck;
          ptr_d   = '0;
        end
      end
      StLoad: begin
        // Withheld in the cycle cpustate moves so a loader write never races a CPU write.
        host_rdy = cs_stable;
        if (host_rdy && bus.host_valid) begin
          load_wr = 1'b1;
          if (ptr_last) state_d = StDone;
          else          ptr_d   = ptr_q + MEM_AW'(1);
        end
      end
      StCheck: begin
        host_rdy = cs_stable;
        if (host_rdy && bus.host_valid) begin
          chk_d   = mem_q[ptr_q];
          state_d = StChkRsp;
        end
      end
      StChkRsp: begin
        chk_vld = 1'b1;
        if (ptr_last) begin
          state_d = StDone;
        end else begin
          ptr_d   = ptr_q + MEM_AW'(1);
          state_d = StCheck;
        end
      end
      StDone: done = 1'b1;
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && !cs_stable) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cpustate_q  <= 2'b00;
      ptr_q       <= '0;
      ar_q        <= '0;
      chk_q       <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpustate_q  <= bus.cpustate;
      ptr_q       <= ptr_d;
      ar_q        <= ar_d;
      chk_q       <= chk_d;
      range_err_q <= range_err_d;
    end
  end

  // RAM has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (load_wr)     mem_q[ptr_q]   <= bus.host_data;
    else if (cpu_wr) mem_q[mem_idx] <= bus.dbus;
  end

  assign bus.mem_dout   = (cpu_rd && in_range) ? mem_q[mem_idx] : '0;
  assign bus.ar         = ar_q;
  assign bus.host_ready = host_rdy;
  assign bus.chk_valid  = chk_vld;
  assign bus.chk_data   = chk_vld ? chk_q : '0;
  assign bus.load_done  = done;
  assign bus.range_err  = range_err_q;

`ifdef MEM_PARITY_EN
  logic par_mem_q [Depth];
  logic chk_par_q, par_err_q, chk_latch, rd_bad, rsp_bad;

  assign chk_latch = (state_q == StCheck) & host_rdy & bus.host_valid;
  assign rd_bad    = cpu_rd & in_range & ((^mem_q[mem_idx]) != par_mem_q[mem_idx]);
  assign rsp_bad   = chk_vld & ((^chk_q) != chk_par_q);

  always_ff @(posedge clk) begin
    if (load_wr)     par_mem_q[ptr_q]   <= ^bus.host_data;
    else if (cpu_wr) par_mem_q[mem_idx] <= ^bus.dbus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_par_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (chk_latch) chk_par_q <= par_mem_q[ptr_q];
      par_err_q <= par_err_q | rd_bad | rsp_bad;
    end
  end

  assign bus.par_err = par_err_q;
`else
  assign bus.par_err = 1'b0;
`endif

endmodule
